// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/scoreboard/debug-walk bundle for regfile_mp
//   master drives ra, we, wa, wd, sb_set, sb_addr, dbg_start, dbg_ready
//   slave drives rd, rbusy, dbg_valid, dbg_idx, dbg_data, dbg_done
interface regfile_mp_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD = 2,
  parameter int NWR = 2
);
  localparam int AW = $clog2(NREG);
  logic [NRD*AW-1:0] ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0] rbusy;
  logic [NWR-1:0] we;
  logic [NWR*AW-1:0] wa;
  logic [NWR*XLEN-1:0] wd;
  logic sb_set;
  logic [AW-1:0] sb_addr;
  logic dbg_start;
  logic dbg_valid;
  logic dbg_ready;
  logic [AW-1:0] dbg_idx;
  logic [XLEN-1:0] dbg_data;
  logic dbg_done;
  modport master(
    output ra, we, wa, wd, sb_set, sb_addr, dbg_start, dbg_ready,
    input rd, rbusy, dbg_valid, dbg_idx, dbg_data, dbg_done
  );
  modport slave(
    input ra, we, wa, wd, sb_set, sb_addr, dbg_start, dbg_ready,
    output rd, rbusy, dbg_valid, dbg_idx, dbg_data, dbg_done
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hardwired, write bypass, busy scoreboard and debug walk
//   clk, rst (sync, active-low) plain ports; all data/handshake signals on bus (slave modport)
module regfile_mp #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter bit BYPASS = 1
) (
  input logic clk,
  input logic rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
  state_t state;
  logic [AW-1:0] idx;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [XLEN-1:0] wval [NREG];
  logic [XLEN-1:0] live [NREG];
  logic [NREG-1:0] whit, shit, nbusy, lbusy;
  // wval is each register's post-edge value; later ports override earlier ones
  always_comb begin
    for (int a = 0; a < NREG; a++) begin
      whit[a] = 1'b0;
      wval[a] = regs[a];
      for (int j = 0; j < NWR; j++)
        if (a != 0 && bus.we[j] && bus.wa[j*AW +: AW] == AW'(a)) begin
          whit[a] = 1'b1;
          wval[a] = bus.wd[j*XLEN +: XLEN];
        end
      shit[a] = a != 0 && bus.sb_set && bus.sb_addr == AW'(a);
      nbusy[a] = shit[a] | (busy[a] & ~whit[a]);
      live[a] = BYPASS ? wval[a] : regs[a];
      // a same-cycle write hides busy, unless a new producer issues to it now
      lbusy[a] = BYPASS ? busy[a] & ~(whit[a] & ~shit[a]) : busy[a];
    end
  end
  always_comb begin
    bus.rd = '0;
    bus.rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      bus.rd[i*XLEN +: XLEN] = live[bus.ra[i*AW +: AW]];
      bus.rbusy[i] = lbusy[bus.ra[i*AW +: AW]];
    end
  end
  always_ff @(posedge clk) begin
    for (int a = 0; a < NREG; a++) regs[a] <= rst ? wval[a] : '0;
    busy <= rst ? nbusy : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
    end else begin
      case (state)
        IDLE: if (bus.dbg_start) begin
          state <= WALK;
          idx <= '0;
        end
        WALK: if (bus.dbg_ready) begin
          state <= idx == AW'(NREG - 1) ? DONE : WALK;
          idx <= idx == AW'(NREG - 1) ? idx : idx + AW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.dbg_valid = state == WALK;
  assign bus.dbg_done = state == DONE;
  assign bus.dbg_idx = idx;
  assign bus.dbg_data = state == WALK ? live[idx] : '0;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random and directed checks of regfile_mp (BYPASS=1 and BYPASS=0 side by side) against an array model
module tb_regfile_mp;
  localparam int XLEN = 64, NREG = 32, NRD = 2, NWR = 2, AW = 5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [XLEN-1:0] m [NREG];
  logic [NREG-1:0] mb;
  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) b1();
  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) b0();
  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut1(.clk(clk), .rst(rst), .bus(b1));
  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut0(.clk(clk), .rst(rst), .bus(b0));
  assign b0.ra = b1.ra;
  assign b0.we = b1.we;
  assign b0.wa = b1.wa;
  assign b0.wd = b1.wd;
  assign b0.sb_set = b1.sb_set;
  assign b0.sb_addr = b1.sb_addr;
  assign b0.dbg_start = b1.dbg_start;
  assign b0.dbg_ready = b1.dbg_ready;
  always #5 clk = ~clk;
  function automatic logic [XLEN-1:0] exp_rd(input int a, input bit byp);
    logic [XLEN-1:0] v = (a == 0) ? '0 : m[a];
    if (byp && a != 0)
      for (int j = 0; j < NWR; j++)
        if (b1.we[j] && int'(b1.wa[j*AW +: AW]) == a) v = b1.wd[j*XLEN +: XLEN];
    return v;
  endfunction
  function automatic logic exp_busy(input int a, input bit byp);
    logic b = mb[a];
    if (byp && !(b1.sb_set && int'(b1.sb_addr) == a))
      for (int j = 0; j < NWR; j++)
        if (b1.we[j] && int'(b1.wa[j*AW +: AW]) == a) b = 1'b0;
    return b;
  endfunction
  task automatic tick;
    @(posedge clk);
    if (!rst) begin
      for (int a = 0; a < NREG; a++) m[a] = '0;
      mb = '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (b1.we[j] && b1.wa[j*AW +: AW] != 0) begin
          m[b1.wa[j*AW +: AW]] = b1.wd[j*XLEN +: XLEN];
          mb[b1.wa[j*AW +: AW]] = 1'b0;
        end
      if (b1.sb_set && b1.sb_addr != 0) mb[b1.sb_addr] = 1'b1;
    end
    #1;
  endtask
  task automatic quiet;
    b1.ra = '0;
    b1.we = '0;
    b1.wa = '0;
    b1.wd = '0;
    b1.sb_set = 1'b0;
    b1.sb_addr = '0;
    b1.dbg_start = 1'b0;
    b1.dbg_ready = 1'b0;
  endtask
  task automatic test_reset;
    quiet();
    rst = 1'b0;
    b1.we = 2'b11;
    b1.wa = {5'd5, 5'd31};
    b1.wd = {64'h1111, 64'h2222};
    b1.sb_set = 1'b1;
    b1.sb_addr = 5'd5;
    tick();
    tick();
    quiet();
    rst = 1'b1;
    b1.ra = {5'd31, 5'd5};
    #1;
    tests++; if (b1.rd !== '0) begin fails++; $display("FAIL reset_rd got %h exp 0", b1.rd); end
    tests++; if (b0.rd !== '0) begin fails++; $display("FAIL reset_rd_nobyp got %h exp 0", b0.rd); end
    tests++; if (b1.rbusy !== 2'b00) begin fails++; $display("FAIL reset_rbusy got %b exp 00", b1.rbusy); end
    tests++; if ({b1.dbg_valid, b1.dbg_done} !== 2'b00) begin fails++; $display("FAIL reset_dbg got %b exp 00", {b1.dbg_valid, b1.dbg_done}); end
    tests++; if ({b1.dbg_idx, b1.dbg_data} !== '0) begin fails++; $display("FAIL reset_dbg_idx_data got %h/%h exp 0/0", b1.dbg_idx, b1.dbg_data); end
    tick();
    tests++; if (b1.rd !== '0) begin fails++; $display("FAIL reset_writes_ignored got %h exp 0", b1.rd); end
  endtask
  task automatic test_conflict;
    quiet();
    b1.we = 2'b11;
    b1.wa = {5'd7, 5'd7};
    b1.wd = {64'hAAAA, 64'h5555};
    b1.ra = {5'd0, 5'd7};
    #1;
    tests++; if (b1.rd[0 +: XLEN] !== 64'hAAAA) begin fails++; $display("FAIL conflict_bypass got %h exp aaaa", b1.rd[0 +: XLEN]); end
    tick();
    b1.we = '0;
    #1;
    tests++; if (b1.rd[0 +: XLEN] !== 64'hAAAA) begin fails++; $display("FAIL conflict_stored got %h exp aaaa", b1.rd[0 +: XLEN]); end
    tests++; if (b0.rd[0 +: XLEN] !== 64'hAAAA) begin fails++; $display("FAIL conflict_stored_nobyp got %h exp aaaa", b0.rd[0 +: XLEN]); end
    b1.we = 2'b01;
    b1.wa = {5'd0, 5'd0};
    b1.wd = {64'h0, 64'h1234};
    b1.ra = {5'd0, 5'd0};
    #1;
    tests++; if (b1.rd !== '0) begin fails++; $display("FAIL x0_bypass got %h exp 0", b1.rd); end
    tick();
    b1.we = '0;
    #1;
    tests++; if (b1.rd !== '0 || b0.rd !== '0) begin fails++; $display("FAIL x0_write got %h/%h exp 0", b1.rd, b0.rd); end
  endtask
  task automatic test_bypass;
    logic [XLEN-1:0] old;
    quiet();
    old = m[3];
    b1.we = 2'b01;
    b1.wa = {5'd0, 5'd3};
    b1.wd = {64'h0, 64'hDEAD};
    b1.ra = {5'd0, 5'd3};
    #1;
    tests++; if (b1.rd[0 +: XLEN] !== 64'hDEAD) begin fails++; $display("FAIL bypass_on got %h exp dead", b1.rd[0 +: XLEN]); end
    tests++; if (b0.rd[0 +: XLEN] !== old) begin fails++; $display("FAIL bypass_off_old got %h exp %h", b0.rd[0 +: XLEN], old); end
    tick();
    b1.we = '0;
    #1;
    tests++; if (b0.rd[0 +: XLEN] !== 64'hDEAD) begin fails++; $display("FAIL bypass_off_next got %h exp dead", b0.rd[0 +: XLEN]); end
  endtask
  task automatic test_scoreboard;
    quiet();
    b1.sb_set = 1'b1;
    b1.sb_addr = 5'd9;
    b1.ra = {5'd0, 5'd9};
    tick();
    b1.sb_set = 1'b0;
    #1;
    tests++; if (b1.rbusy[0] !== 1'b1 || b0.rbusy[0] !== 1'b1) begin fails++; $display("FAIL sb_set got %b/%b exp 1/1", b1.rbusy[0], b0.rbusy[0]); end
    b1.we = 2'b10;
    b1.wa = {5'd9, 5'd0};
    b1.wd = {64'h99, 64'h0};
    #1;
    tests++; if (b1.rbusy[0] !== 1'b0 || b0.rbusy[0] !== 1'b1) begin fails++; $display("FAIL sb_clear_same got %b/%b exp 0/1", b1.rbusy[0], b0.rbusy[0]); end
    tick();
    b1.we = '0;
    #1;
    tests++; if (b1.rbusy[0] !== 1'b0 || b0.rbusy[0] !== 1'b0) begin fails++; $display("FAIL sb_clear_next got %b/%b exp 0/0", b1.rbusy[0], b0.rbusy[0]); end
    b1.we = 2'b01;
    b1.wa = {5'd0, 5'd9};
    b1.sb_set = 1'b1;
    tick();
    quiet();
    b1.ra = {5'd0, 5'd9};
    #1;
    tests++; if (b1.rbusy[0] !== 1'b1 || b0.rbusy[0] !== 1'b1) begin fails++; $display("FAIL sb_set_wins got %b/%b exp 1/1", b1.rbusy[0], b0.rbusy[0]); end
    b1.we = 2'b01;
    b1.wa = {5'd0, 5'd9};
    b1.sb_set = 1'b1;
    b1.sb_addr = 5'd9;
    #1;
    tests++; if (b1.rbusy[0] !== 1'b1) begin fails++; $display("FAIL sb_set_wins_bypass got %b exp 1", b1.rbusy[0]); end
    tick();
    quiet();
    b1.sb_set = 1'b1;
    b1.sb_addr = 5'd0;
    tick();
    b1.sb_set = 1'b0;
    #1;
    tests++; if (b1.rbusy !== 2'b00 || b0.rbusy !== 2'b00) begin fails++; $display("FAIL sb_x0 got %b/%b exp 00/00", b1.rbusy, b0.rbusy); end
  endtask
  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      quiet();
      for (int j = 0; j < NWR; j++) begin
        b1.we[j] = 1'($urandom_range(0, 1));
        b1.wa[j*AW +: AW] = AW'($urandom_range(0, c[0] ? 7 : 31));
        b1.wd[j*XLEN +: XLEN] = {$urandom, $urandom};
      end
      for (int i = 0; i < NRD; i++) b1.ra[i*AW +: AW] = AW'($urandom_range(0, c[1] ? 7 : 31));
      b1.sb_set = ($urandom_range(0, 3) == 0);
      b1.sb_addr = AW'($urandom_range(0, 7));
      #1;
      for (int i = 0; i < NRD; i++) begin
        int a = int'(b1.ra[i*AW +: AW]);
        tests++; if (b1.rd[i*XLEN +: XLEN] !== exp_rd(a, 1)) begin fails++; $display("FAIL rand_rd_byp c%0d p%0d x%0d got %h exp %h", c, i, a, b1.rd[i*XLEN +: XLEN], exp_rd(a, 1)); end
        tests++; if (b0.rd[i*XLEN +: XLEN] !== exp_rd(a, 0)) begin fails++; $display("FAIL rand_rd_nobyp c%0d p%0d x%0d got %h exp %h", c, i, a, b0.rd[i*XLEN +: XLEN], exp_rd(a, 0)); end
        tests++; if (b1.rbusy[i] !== exp_busy(a, 1)) begin fails++; $display("FAIL rand_busy_byp c%0d p%0d x%0d got %b exp %b", c, i, a, b1.rbusy[i], exp_busy(a, 1)); end
        tests++; if (b0.rbusy[i] !== exp_busy(a, 0)) begin fails++; $display("FAIL rand_busy_nobyp c%0d p%0d x%0d got %b exp %b", c, i, a, b0.rbusy[i], exp_busy(a, 0)); end
      end
      tick();
    end
  endtask
  task automatic test_walk;
    int nxt = 0;
    int dones = 0;
    quiet();
    for (int r = 1; r < NREG; r++) begin
      b1.we = 2'b01;
      b1.wa = {5'd0, AW'(r)};
      b1.wd = {64'h0, 64'(r * 'h11)};
      tick();
    end
    quiet();
    b1.dbg_start = 1'b1;
    tick();
    b1.dbg_start = 1'b0;
    for (int c = 0; c < 200 && dones == 0; c++) begin
      b1.dbg_ready = c[0];
      b1.dbg_start = (c == 9);
      #1;
      if (b1.dbg_done) begin
        dones++;
        tests++; if (nxt !== NREG) begin fails++; $display("FAIL walk_done_early got %0d beats exp %0d", nxt, NREG); end
      end else begin
        tests++; if (b1.dbg_valid !== 1'b1) begin fails++; $display("FAIL walk_valid c%0d got %b exp 1", c, b1.dbg_valid); end
        tests++; if (int'(b1.dbg_idx) !== nxt) begin fails++; $display("FAIL walk_idx c%0d got %0d exp %0d", c, b1.dbg_idx, nxt); end
        tests++; if (b1.dbg_data !== 64'(nxt * 'h11)) begin fails++; $display("FAIL walk_data c%0d got %h exp %h", c, b1.dbg_data, 64'(nxt * 'h11)); end
        if (b1.dbg_ready) nxt++;
      end
      tick();
    end
    quiet();
    tests++; if (dones !== 1) begin fails++; $display("FAIL walk_done_seen got %0d exp 1", dones); end
    #1;
    tests++; if ({b1.dbg_valid, b1.dbg_done} !== 2'b00) begin fails++; $display("FAIL walk_idle_after got %b exp 00", {b1.dbg_valid, b1.dbg_done}); end
  endtask
  task automatic test_reset_mid_walk;
    int dones = 0;
    quiet();
    b1.dbg_start = 1'b1;
    tick();
    b1.dbg_start = 1'b0;
    b1.dbg_ready = 1'b1;
    repeat (12) tick();
    tests++; if (b1.dbg_valid !== 1'b1 || b1.dbg_idx !== 5'd12) begin fails++; $display("FAIL midwalk_pos got %b/%0d exp 1/12", b1.dbg_valid, b1.dbg_idx); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    tests++; if ({b1.dbg_valid, b1.dbg_done} !== 2'b00) begin fails++; $display("FAIL midwalk_abort got %b exp 00", {b1.dbg_valid, b1.dbg_done}); end
    tick();
    tests++; if (b1.dbg_done !== 1'b0) begin fails++; $display("FAIL midwalk_no_done got %b exp 0", b1.dbg_done); end
    b1.dbg_start = 1'b1;
    b1.dbg_ready = 1'b0;
    tick();
    b1.dbg_start = 1'b0;
    tests++; if (b1.dbg_valid !== 1'b1 || b1.dbg_idx !== 5'd0 || b1.dbg_data !== '0) begin fails++; $display("FAIL restart got %b/%0d/%h exp 1/0/0", b1.dbg_valid, b1.dbg_idx, b1.dbg_data); end
    b1.dbg_ready = 1'b1;
    for (int c = 0; c < 100 && dones == 0; c++) begin
      if (b1.dbg_done) dones++;
      tick();
    end
    tests++; if (dones !== 1) begin fails++; $display("FAIL restart_done got %0d exp 1", dones); end
  endtask
  initial begin
    quiet();
    test_reset();
    test_conflict();
    test_bypass();
    test_scoreboard();
    test_random();
    test_walk();
    test_reset_mid_walk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
